// File: rtl/alu_share_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_share_ctrl                                                |
// | Purpose  : Round-robin sequencer that shares one combinational 4-bit ALU |
// |            between two requesters. It registers the winner's operands,   |
// |            waits SETTLE cycles, captures result/carry and returns them    |
// |            on a valid/ready response channel tagged with the winner ID.  |
// | Ports    : clk, rst_n (async active-low)                                  |
// |            req_valid/req_ready[1:0], req{0,1}_op/_a/_b : request side     |
// |            alu_code/alu_a/alu_b -> ALU, alu_result/alu_flag_c <- ALU      |
// |            rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_flag_c : response   |
// |            busy : high whenever the sequencer is not idle                 |
// | Option   : ALU_SHARE_CTRL_STATS_EN adds grant_cnt0/grant_cnt1, STAT_W bit |
// |            saturating per-requester grant counters.                       |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module alu_share_ctrl #(
  parameter int SETTLE = 1,
  parameter int STAT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [2:0]  req0_op,
  input  logic [3:0]  req0_a,
  input  logic [3:0]  req0_b,
  input  logic [2:0]  req1_op,
  input  logic [3:0]  req1_a,
  input  logic [3:0]  req1_b,
  output logic [2:0]  alu_code,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  input  logic [7:0]  alu_result,
  input  logic        alu_flag_c,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [7:0]  rsp_result,
  output logic        rsp_flag_c,
  output logic        busy
`ifdef ALU_SHARE_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0] grant_cnt0,
  output logic [STAT_W-1:0] grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [3:0] c_settle_load = 4'(SETTLE - 1);

  // Elaboration-time parameter sanity checks.
  generate
    if ((SETTLE < 1) || (SETTLE > 15)) begin : g_bad_settle
      $error("alu_share_ctrl: SETTLE must be in 1..15");
    end
    if (STAT_W < 1) begin : g_bad_stat_w
      $error("alu_share_ctrl: STAT_W must be at least 1");
    end
  endgenerate

  state_t      state_q, state_d;
  logic [2:0]  alu_code_q, alu_code_d;
  logic [3:0]  alu_a_q, alu_a_d;
  logic [3:0]  alu_b_q, alu_b_d;
  logic        idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [7:0]  rsp_result_q, rsp_result_d;
  logic        rsp_flag_c_q, rsp_flag_c_d;
  logic        last_grant_q, last_grant_d;

  logic        w_win;

  // Under contention the requester that did not win last time is favoured;
  // otherwise the single active requester wins.
  assign w_win = (&req_valid) ? ~last_grant_q : req_valid[1];

  always_comb begin
    state_d      = state_q;
    alu_code_d   = alu_code_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flag_c_d = rsp_flag_c_q;
    last_grant_d = last_grant_q;
    req_ready    = 2'b00;

    case (state_q)
      IDLE: begin
        // Ready is only raised towards a valid winner, so any ready is also
        // a completed handshake.
        if (|req_valid) begin
          req_ready  = w_win ? 2'b10 : 2'b01;
          alu_code_d = w_win ? req1_op : req0_op;
          alu_a_d    = w_win ? req1_a  : req0_a;
          alu_b_d    = w_win ? req1_b  : req0_b;
          idx_d      = w_win;
          cnt_d      = c_settle_load;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d = CAPT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CAPT: begin
        rsp_result_d = alu_result;
        // Carry is only meaningful for add (000) and sub (001).
        rsp_flag_c_d = (alu_code_q[2:1] == 2'b00) & alu_flag_c;
        rsp_id_d     = idx_q;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d  = 1'b0;
          last_grant_d = rsp_id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      alu_code_q   <= 3'd0;
      alu_a_q      <= 4'd0;
      alu_b_q      <= 4'd0;
      idx_q        <= 1'b0;
      cnt_q        <= 4'd0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 8'd0;
      rsp_flag_c_q <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      alu_code_q   <= alu_code_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flag_c_q <= rsp_flag_c_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign alu_code   = alu_code_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flag_c = rsp_flag_c_q;
  assign busy       = (state_q != IDLE);

`ifdef ALU_SHARE_CTRL_STATS_EN
  logic [STAT_W-1:0] grant_cnt0_q, grant_cnt0_d;
  logic [STAT_W-1:0] grant_cnt1_q, grant_cnt1_d;

  // Saturating grant counters, stepped on each request handshake.
  always_comb begin
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    if (req_ready[0] && !(&grant_cnt0_q)) begin
      grant_cnt0_d = grant_cnt0_q + 1'b1;
    end
    if (req_ready[1] && !(&grant_cnt1_q)) begin
      grant_cnt1_d = grant_cnt1_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_share_ctrl                                             |
// | Purpose  : Self-checking bench for alu_share_ctrl: table vectors, hand    |
// |            sequences for arbitration/stall/reset, and a randomized run    |
// |            against a transaction-level reference model.                   |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_alu_share_ctrl;

  localparam int SETTLE_A = 1;
  localparam int SETTLE_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Instance with SETTLE_A
  logic [1:0] req_valid, req_ready;
  logic [2:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] alu_code;
  logic [3:0] alu_a, alu_b;
  logic [7:0] alu_result;
  logic       alu_flag_c;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_flag_c, busy;
  logic [7:0] rsp_result;
  logic       force_flag;

  // Instance with SETTLE_B
  logic [1:0] d4_req_valid, d4_req_ready;
  logic [2:0] d4_req0_op, d4_req1_op;
  logic [3:0] d4_req0_a, d4_req0_b, d4_req1_a, d4_req1_b;
  logic [2:0] d4_alu_code;
  logic [3:0] d4_alu_a, d4_alu_b;
  logic [7:0] d4_alu_result;
  logic       d4_alu_flag_c;
  logic       d4_rsp_valid, d4_rsp_ready, d4_rsp_id, d4_rsp_flag_c, d4_busy;
  logic [7:0] d4_rsp_result;

`ifdef ALU_SHARE_CTRL_STATS_EN
  logic [7:0] gc0, gc1, d4_gc0, d4_gc1;
`endif

  alu_share_ctrl #(.SETTLE(SETTLE_A)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_code(alu_code), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flag_c(alu_flag_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flag_c(rsp_flag_c), .busy(busy)
`ifdef ALU_SHARE_CTRL_STATS_EN
    , .grant_cnt0(gc0), .grant_cnt1(gc1)
`endif
  );

  alu_share_ctrl #(.SETTLE(SETTLE_B)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(d4_req_valid), .req_ready(d4_req_ready),
    .req0_op(d4_req0_op), .req0_a(d4_req0_a), .req0_b(d4_req0_b),
    .req1_op(d4_req1_op), .req1_a(d4_req1_a), .req1_b(d4_req1_b),
    .alu_code(d4_alu_code), .alu_a(d4_alu_a), .alu_b(d4_alu_b),
    .alu_result(d4_alu_result), .alu_flag_c(d4_alu_flag_c),
    .rsp_valid(d4_rsp_valid), .rsp_ready(d4_rsp_ready), .rsp_id(d4_rsp_id),
    .rsp_result(d4_rsp_result), .rsp_flag_c(d4_rsp_flag_c), .busy(d4_busy)
`ifdef ALU_SHARE_CTRL_STATS_EN
    , .grant_cnt0(d4_gc0), .grant_cnt1(d4_gc1)
`endif
  );

  // Behavioural ALU: {carry, result}. Non add/sub ops pass the forced flag.
  function automatic logic [8:0] alu_fn(input logic [2:0] code, input logic [3:0] a,
                                        input logic [3:0] b, input logic fflag);
    logic [7:0] r;
    logic       f;
    f = fflag;
    case (code)
      3'd0: begin r = 8'(a) + 8'(b); f = r[4]; end
      3'd1: begin r = 8'(a) - 8'(b); f = (a < b); end
      3'd2: r = 8'(a) * 8'(b);
      3'd3: r = {4'h0, a & b};
      3'd4: r = {4'h0, a | b};
      3'd5: r = {3'b000, a, 1'b0};
      3'd6: r = {5'b00000, a[3:1]};
      default: r = {4'h0, a ^ b};
    endcase
    return {f, r};
  endfunction

  always_comb {alu_flag_c, alu_result} = alu_fn(alu_code, alu_a, alu_b, force_flag);
  always_comb {d4_alu_flag_c, d4_alu_result} = alu_fn(d4_alu_code, d4_alu_a, d4_alu_b, 1'b0);

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic id, input logic [2:0] op, input logic [3:0] a,
                           input logic [3:0] b);
    if (id) begin
      req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    @(negedge clk);
    while (busy && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
    tick();
  endtask

  typedef struct {
    logic       id;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       ff;
    logic [7:0] res;
    logic       flg;
  } vec_t;

  typedef struct {
    logic       id;
    logic [7:0] res;
    logic       flg;
  } exp_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl [10];
    exp_t       q[$];
    exp_t       e;
    logic       g [4];
    int         ng;
    int         c;
    logic       outstanding;
    logic       model_last;
    int         acc_cyc;
    logic [1:0] exp_rr;
    logic [1:0] hs_prev;
    logic [8:0] m;
    logic       wid;
    logic [2:0] wop;

    tbl[0] = '{1'b0, 3'd0, 4'd9,  4'd8,  1'b0, 8'h11, 1'b1};
    tbl[1] = '{1'b1, 3'd1, 4'd3,  4'd5,  1'b0, 8'hFE, 1'b1};
    tbl[2] = '{1'b0, 3'd2, 4'd15, 4'd15, 1'b1, 8'hE1, 1'b0};
    tbl[3] = '{1'b1, 3'd7, 4'hA,  4'h5,  1'b1, 8'h0F, 1'b0};
    tbl[4] = '{1'b0, 3'd3, 4'hC,  4'hA,  1'b1, 8'h08, 1'b0};
    tbl[5] = '{1'b1, 3'd4, 4'h3,  4'h8,  1'b0, 8'h0B, 1'b0};
    tbl[6] = '{1'b0, 3'd0, 4'd3,  4'd4,  1'b1, 8'h07, 1'b0};
    tbl[7] = '{1'b1, 3'd1, 4'd7,  4'd7,  1'b1, 8'h00, 1'b0};
    tbl[8] = '{1'b0, 3'd5, 4'hF,  4'h0,  1'b1, 8'h1E, 1'b0};
    tbl[9] = '{1'b1, 3'd6, 4'h9,  4'h0,  1'b1, 8'h04, 1'b0};

    rst_n = 1'b0;
    req_valid = 2'b00; rsp_ready = 1'b0; force_flag = 1'b0;
    req0_op = 3'd0; req0_a = 4'd0; req0_b = 4'd0;
    req1_op = 3'd0; req1_a = 4'd0; req1_b = 4'd0;
    d4_req_valid = 2'b00; d4_rsp_ready = 1'b0;
    d4_req0_op = 3'd0; d4_req0_a = 4'd0; d4_req0_b = 4'd0;
    d4_req1_op = 3'd0; d4_req1_a = 4'd0; d4_req1_b = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_req_ready",  32'(req_ready),  32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    check("rst_rsp_id",     32'(rsp_id),     32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    check("rst_rsp_flag_c", 32'(rsp_flag_c), 32'd0);
    check("rst_alu_code",   32'(alu_code),   32'd0);
    check("rst_alu_a",      32'(alu_a),      32'd0);
    check("rst_alu_b",      32'(alu_b),      32'd0);
    tick();

    // Table vectors: single requester, full timing of one transaction
    for (int i = 0; i < 10; i++) begin
      drive_req(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b);
      force_flag = tbl[i].ff;
      rsp_ready  = 1'b1;
      req_valid  = tbl[i].id ? 2'b10 : 2'b01;
      @(negedge clk);
      check("vec_req_ready", 32'(req_ready), tbl[i].id ? 32'd2 : 32'd1);
      tick();
      req_valid = 2'b00;
      @(negedge clk);
      check("vec_exec_busy",  32'(busy),      32'd1);
      check("vec_alu_code",   32'(alu_code),  32'(tbl[i].op));
      check("vec_alu_a",      32'(alu_a),     32'(tbl[i].a));
      check("vec_alu_b",      32'(alu_b),     32'(tbl[i].b));
      check("vec_early_rsp1", 32'(rsp_valid), 32'd0);
      tick();
      @(negedge clk);
      check("vec_early_rsp2", 32'(rsp_valid), 32'd0);
      tick();
      @(negedge clk);
      check("vec_rsp_valid",  32'(rsp_valid),  32'd1);
      check("vec_rsp_id",     32'(rsp_id),     32'(tbl[i].id));
      check("vec_rsp_result", 32'(rsp_result), 32'(tbl[i].res));
      check("vec_rsp_flag_c", 32'(rsp_flag_c), 32'(tbl[i].flg));
      tick();
      @(negedge clk);
      check("vec_done_busy",  32'(busy),      32'd0);
      check("vec_done_valid", 32'(rsp_valid), 32'd0);
      tick();
    end

    // Contention: both valid continuously, grants must alternate 0,1,0,1
    drive_req(1'b0, 3'd0, 4'd1, 4'd2);
    drive_req(1'b1, 3'd7, 4'd5, 4'd3);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    ng = 0;
    for (int k = 0; k < 60 && ng < 4; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        g[ng] = req_ready[1];
        ng++;
      end
      tick();
    end
    req_valid = 2'b00;
    check("rr_grant_count", 32'(ng), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check("rr_grant_order", 32'(g[k]), 32'(k % 2));
    end
    wait_idle();

    // Response stall: rsp_ready low for 5 cycles in RESP
    drive_req(1'b0, 3'd4, 4'd5, 4'd2);
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("stall_accept", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b10;
    drive_req(1'b1, 3'd0, 4'd1, 4'd1);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_rsp_valid",  32'(rsp_valid),  32'd1);
      check("stall_rsp_result", 32'(rsp_result), 32'h07);
      check("stall_rsp_id",     32'(rsp_id),     32'd0);
      check("stall_req_ready",  32'(req_ready),  32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_last_valid", 32'(rsp_valid), 32'd1);
    tick();
    @(negedge clk);
    check("stall_rel_busy",  32'(busy),      32'd0);
    check("stall_rel_valid", 32'(rsp_valid), 32'd0);
    check("stall_rel_grant", 32'(req_ready), 32'd2);
    tick();
    req_valid = 2'b00;
    wait_idle();

    // Second instance: complete one req0 op so its last grant becomes 0
    d4_req0_op = 3'd0; d4_req0_a = 4'd1; d4_req0_b = 4'd1;
    d4_rsp_ready = 1'b1;
    d4_req_valid = 2'b01;
    tick();
    d4_req_valid = 2'b00;
    c = 0;
    @(negedge clk);
    while (!d4_rsp_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("s4_latency",    32'(c),             32'(SETTLE_B + 1));
    check("s4_rsp_result", 32'(d4_rsp_result), 32'h02);
    check("s4_rsp_id",     32'(d4_rsp_id),     32'd0);
    check("s4_rsp_flag_c", 32'(d4_rsp_flag_c), 32'd0);
    tick();

    // Reset asserted mid-EXEC aborts silently
    d4_req0_a = 4'd7;
    d4_req_valid = 2'b01;
    tick();
    d4_req_valid = 2'b00;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",      32'(d4_busy),      32'd0);
    check("arst_alu_code",  32'(d4_alu_code),  32'd0);
    check("arst_alu_a",     32'(d4_alu_a),     32'd0);
    check("arst_alu_b",     32'(d4_alu_b),     32'd0);
    check("arst_rsp_valid", 32'(d4_rsp_valid), 32'd0);
    check("arst_req_ready", 32'(d4_req_ready), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("arst_no_rsp", 32'(d4_rsp_valid), 32'd0);
      tick();
    end
    d4_req_valid = 2'b11;
    @(negedge clk);
    check("arst_first_grant", 32'(d4_req_ready), 32'd1);
    d4_req_valid = 2'b00;
    tick();

    // Randomized traffic against a transaction-level model
    outstanding = 1'b0;
    model_last  = 1'b1;
    acc_cyc     = 0;
    hs_prev     = 2'b00;
    req_valid   = 2'b00;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (hs_prev[i]) begin
          req_valid[i] = 1'b0;
        end else if (req_valid[i]) begin
          if ($urandom_range(15) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          req_valid[i] = 1'b1;
          drive_req(1'(i), 3'($urandom_range(7)), 4'($urandom_range(15)),
                    4'($urandom_range(15)));
        end
      end
      rsp_ready  = 1'($urandom_range(1));
      force_flag = 1'($urandom_range(1));
      @(negedge clk);

      exp_rr = 2'b00;
      if (!outstanding) begin
        case (req_valid)
          2'b01:   exp_rr = 2'b01;
          2'b10:   exp_rr = 2'b10;
          2'b11:   exp_rr = model_last ? 2'b01 : 2'b10;
          default: exp_rr = 2'b00;
        endcase
      end
      check("rnd_req_ready", 32'(req_ready), 32'(exp_rr));
      check("rnd_rsp_valid", 32'(rsp_valid),
            32'(outstanding && (cyc >= acc_cyc + SETTLE_A + 2)));

      if (rsp_valid && rsp_ready) begin
        check("rnd_rsp_pending", 32'(q.size()), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("rnd_rsp_id",     32'(rsp_id),     32'(e.id));
          check("rnd_rsp_result", 32'(rsp_result), 32'(e.res));
          check("rnd_rsp_flag_c", 32'(rsp_flag_c), 32'(e.flg));
          model_last = e.id;
        end
        outstanding = 1'b0;
      end

      if (exp_rr != 2'b00) begin
        wid   = exp_rr[1];
        wop   = wid ? req1_op : req0_op;
        m     = wid ? alu_fn(req1_op, req1_a, req1_b, 1'b0)
                    : alu_fn(req0_op, req0_a, req0_b, 1'b0);
        e.id  = wid;
        e.res = m[7:0];
        e.flg = (wop <= 3'd1) ? m[8] : 1'b0;
        q.push_back(e);
        outstanding = 1'b1;
        acc_cyc     = cyc;
      end
      hs_prev = req_ready & req_valid;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
Sequencer and round-robin arbiter that shares one 4-bit combinational ALU between two requesters.
- Each requester issues (op, a, b) over a valid/ready handshake.
- The controller drives the ALU from registered operands and waits a programmable settle time.
- It then captures result and carry flag and returns them to the winning requester over a valid/ready response channel tagged with its ID.

Parameters:
SETTLE, 1, cycles the ALU inputs are held stable before capture; legal range 1..15.
STAT_W, 8, width of each grant counter (used only with the optional feature).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  2  per-requester request valid; bit i = requester i.
req_ready  output  2  per-requester accept strobe; one-hot or zero.
req0_op  input  3  requester 0 ALU code (000 add … 111 xor).
req0_a  input  4  requester 0 operand a.
req0_b  input  4  requester 0 operand b.
req1_op  input  3  requester 1 ALU code.
req1_a  input  4  requester 1 operand a.
req1_b  input  4  requester 1 operand b.
alu_code  output  3  registered code to the ALU.
alu_a  output  4  registered operand a to the ALU.
alu_b  output  4  registered operand b to the ALU.
alu_result  input  8  ALU result.
alu_flag_c  input  1  ALU carry flag.
rsp_valid  output  1  response valid.
rsp_ready  input  1  response consumer ready.
rsp_id  output  1  requester index owning the response.
rsp_result  output  8  captured result.
rsp_flag_c  output  1  captured carry, qualified by op.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: single clock clk; rst_n asynchronous assert, synchronous deassert, active-low.
- Reset values:
  - state = IDLE.
  - alu_code/alu_a/alu_b = 0.
  - rsp_valid/rsp_id/rsp_result/rsp_flag_c = 0.
  - busy = 0.
  - last_grant = 1, so requester 0 wins the first contention.
- FSM states: IDLE, EXEC, CAPT, RESP.
- IDLE:
  - req_ready is combinational: nonzero only in IDLE, one-hot on the winner.
  - Winner selection:
    - If only one req_valid bit is set, that requester wins.
    - If both are set, the requester != last_grant wins.
  - On the handshake (valid & ready) the winner's op/a/b is registered onto alu_code/alu_a/alu_b, its index is stored, the settle counter is loaded with SETTLE-1, and the FSM moves to EXEC.
- EXEC:
  - ALU inputs are held constant.
  - When the counter reaches 0, go to CAPT; otherwise decrement.
- CAPT:
  - rsp_result <= alu_result.
  - rsp_flag_c <= alu_flag_c if alu_code is 000 or 001, else 0. The ALU flag is stale for other ops.
  - rsp_id <= stored index; rsp_valid <= 1.
  - Go to RESP.
- RESP:
  - rsp_* are held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1: rsp_valid <= 0, last_grant <= rsp_id, go to IDLE.
  - No new request is accepted in the same cycle.
- Latency: handshake at edge T gives rsp_valid high after edge T+SETTLE+1. With SETTLE=1, rsp_valid is seen in cycle T+2 after acceptance.
- Throughput: at most one operation per SETTLE+3 cycles (rsp_ready held high).
- Boundaries:
  - A request that drops valid before ready is ignored, with no state change.
  - A requester holding valid through RESP is served on the next IDLE, subject to round-robin.
  - rsp_ready high while rsp_valid is low has no effect.
  - Reset mid-operation aborts the transaction silently: no response, and last_grant returns to 1.
- busy = (state != IDLE).

Optional Feature:
Macro ALU_SHARE_CTRL_STATS_EN.
- When defined, adds outputs grant_cnt0 and grant_cnt1, each STAT_W wide.
  - Each counter increments on its requester's request handshake.
  - Counters saturate at all-ones and reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then req0 add a=9 b=8 alone, rsp_ready=1 → req_ready=01 for one cycle; rsp_valid after 2 edges with rsp_id=0, rsp_result=0x11, rsp_flag_c=alu_flag_c; busy back to 0 after RESP.
- req1 sub a=3 b=5 (ALU model returns 0xFE, flag 1) → rsp_id=1, rsp_result=0xFE, rsp_flag_c=1.
- req0 mul a=15 b=15 with ALU flag input forced 1 → rsp_result=0xE1, rsp_flag_c=0 (flag suppressed for non add/sub).
- Both valid continuously for 4 operations → grant order 0,1,0,1; never two consecutive grants to one requester.
- rsp_ready held 0 for 5 cycles in RESP → rsp_* stable, req_ready=00, no new acceptance; release gives IDLE next cycle.
- Assert rst_n=0 during EXEC with SETTLE=4 → all outputs 0 immediately (asynchronous); no response emitted; after release, contention grants requester 0.
